// File: rtl/div_unit.sv
// Iterative restoring divider: 32 cycles per nonzero-divisor result,
// immediate result for a zero divisor, valid/ready handshake on both sides.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  is_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_zero,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;

    // Working registers. a_reg starts as the dividend magnitude shifted up by
    // one so its MSB is always the next bit to bring in; quotient bits enter
    // at the bottom, so after W steps its low W bits hold the quotient.
    logic [W:0]    a_reg;
    logic [W:0]    b_mag;
    logic [W:0]    r_acc;
    logic          neg_q;
    logic          neg_r;

    logic                accept;
    logic                zero_div;
    logic                last_step;
    logic [W+1:0]        r_shift;
    logic signed [W+1:0] diff;
    logic                q_bit;
    logic [W:0]          r_next;
    logic [W:0]          a_next;

    // Magnitude is one bit wider than the operand so 0x80000000 stays positive.
    function automatic logic [W:0] magnitude(input logic signed [W-1:0] v, input logic sgn);
        if (sgn && (v < 0))
            return {1'b0, ~v} + {{W{1'b0}}, 1'b1};
        else
            return {1'b0, v};
    endfunction

    function automatic logic [W-1:0] apply_sign(input logic [W-1:0] m, input logic neg);
        return neg ? (~m + {{(W-1){1'b0}}, 1'b1}) : m;
    endfunction

    assign accept    = (state == IDLE) && in_valid;
    assign zero_div  = (divisor == '0);
    assign last_step = (state == CALC) && (count == LAST);

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        r_shift = {r_acc, a_reg[W]};
        diff    = signed'(r_shift) - signed'({1'b0, b_mag});
        q_bit   = (diff >= 0);
        r_next  = q_bit ? diff[W:0] : r_shift[W:0];
        a_next  = {a_reg[W-1:0], q_bit};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = zero_div ? DONE : CALC;
            CALC:    if (count == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            CALC:    busy      = 1'b1;
            DONE:    begin out_valid = 1'b1; busy = 1'b1; end
            default: in_ready  = 1'b0;
        endcase
    end

    // Step counter and result registers; results only change on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            count <= '0;
            if (zero_div) begin
                quotient  <= '1;
                remainder <= dividend;
                div_zero  <= 1'b1;
            end
        end else if (state == CALC) begin
            count <= count + CW'(1);
            if (last_step) begin
                quotient  <= apply_sign(a_next[W-1:0], neg_q);
                remainder <= apply_sign(r_next[W-1:0], neg_r);
                div_zero  <= 1'b0;
            end
        end
    end

    // Operand capture on accept, then one shift/subtract per CALC cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= magnitude(dividend, is_signed) << 1;
            b_mag <= magnitude(divisor, is_signed);
            r_acc <= '0;
            neg_q <= is_signed && (dividend[W-1] ^ divisor[W-1]);
            neg_r <= is_signed && dividend[W-1];
        end else if (state == CALC) begin
            a_reg <= a_next;
            r_acc <= r_next;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;
    logic        busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
        .remainder(remainder), .div_zero(div_zero), .busy(busy)
    );

    // Present one operand set for exactly one edge (E0); returns at E0+1 with
    // junk on the operand inputs so that late sampling would be noticed.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk); #1;
        in_valid = 1'b1; dividend = a; divisor = b; is_signed = s;
        @(posedge clk); #1;
        in_valid = 1'b0; dividend = 32'hDEADBEEF; divisor = 32'h0; is_signed = ~s;
    endtask

    // Count edges until out_valid, bounded to 40.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (quotient !== 32'h0) begin bad++; $display("FAIL rst_quotient: got %h want 0", quotient); end
        total++; if (remainder !== 32'h0) begin bad++; $display("FAIL rst_remainder: got %h want 0", remainder); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL rst_div_zero: got %b want 0", div_zero); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        start_op(32'd100, 32'd7, 1'b0);
        repeat (31) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL uns_early_valid: got %b want 0 after E31", out_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL uns_busy_calc: got %b want 1", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL uns_ready_calc: got %b want 0", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL uns_valid_e32: got %b want 1", out_valid); end
        total++; if (quotient !== 32'd14) begin bad++; $display("FAIL uns_quotient: got %h want %h", quotient, 32'd14); end
        total++; if (remainder !== 32'd2) begin bad++; $display("FAIL uns_remainder: got %h want %h", remainder, 32'd2); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL uns_div_zero: got %b want 0", div_zero); end
        finish_op();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL uns_back_idle: valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
        total++; if (quotient !== 32'd14 || remainder !== 32'd2) begin bad++; $display("FAIL uns_hold_idle: got %h/%h want 0000000e/00000002", quotient, remainder); end
    endtask

    task automatic test_signed();
        logic [31:0] a_t [4] = '{32'hFFFFFF9C, 32'h00000064, 32'hFFFFFF9C, 32'hFFFFFF9C};
        logic [31:0] b_t [4] = '{32'h00000007, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h00000007};
        logic        s_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] q_t [4] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'h0000000E, 32'h24924916};
        logic [31:0] r_t [4] = '{32'hFFFFFFFE, 32'h00000002, 32'hFFFFFFFE, 32'h00000002};
        int n;
        for (int i = 0; i < 4; i++) begin
            start_op(a_t[i], b_t[i], s_t[i]);
            wait_out(n);
            total++; if (n !== 32) begin bad++; $display("FAIL sgn%0d_latency: got %0d edges want 32", i, n); end
            total++; if (quotient !== q_t[i]) begin bad++; $display("FAIL sgn%0d_quotient: got %h want %h", i, quotient, q_t[i]); end
            total++; if (remainder !== r_t[i]) begin bad++; $display("FAIL sgn%0d_remainder: got %h want %h", i, remainder, r_t[i]); end
            total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL sgn%0d_div_zero: got %b want 0", i, div_zero); end
            finish_op();
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] a_t [3] = '{32'h12345678, 32'h80000000, 32'hFFFFFF9C};
        logic        s_t [3] = '{1'b0, 1'b1, 1'b1};
        int n;
        for (int i = 0; i < 3; i++) begin
            start_op(a_t[i], 32'h0, s_t[i]);
            wait_out(n);
            total++; if (n !== 0) begin bad++; $display("FAIL dz%0d_latency: got %0d edges want 0", i, n); end
            total++; if (quotient !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz%0d_quotient: got %h want ffffffff", i, quotient); end
            total++; if (remainder !== a_t[i]) begin bad++; $display("FAIL dz%0d_remainder: got %h want %h", i, remainder, a_t[i]); end
            total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz%0d_flag: got %b want 1", i, div_zero); end
            finish_op();
        end
        total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_hold_idle: got %b want 1", div_zero); end
    endtask

    task automatic test_overflow();
        logic        s_t [2] = '{1'b1, 1'b0};
        logic [31:0] q_t [2] = '{32'h80000000, 32'h00000000};
        logic [31:0] r_t [2] = '{32'h00000000, 32'h80000000};
        int n;
        for (int i = 0; i < 2; i++) begin
            start_op(32'h80000000, 32'hFFFFFFFF, s_t[i]);
            wait_out(n);
            total++; if (n !== 32) begin bad++; $display("FAIL ovf%0d_latency: got %0d edges want 32", i, n); end
            total++; if (quotient !== q_t[i]) begin bad++; $display("FAIL ovf%0d_quotient: got %h want %h", i, quotient, q_t[i]); end
            total++; if (remainder !== r_t[i]) begin bad++; $display("FAIL ovf%0d_remainder: got %h want %h", i, remainder, r_t[i]); end
            total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL ovf%0d_div_zero: got %b want 0", i, div_zero); end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int n;
        start_op(32'd1000, 32'd10, 1'b0);
        wait_out(n);
        total++; if (n !== 32) begin bad++; $display("FAIL bp_latency: got %0d edges want 32", n); end
        // Offer a zero-divisor operand while DONE; it must not be taken.
        in_valid = 1'b1; dividend = 32'h5; divisor = 32'h0; is_signed = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd100 || remainder !== 32'd0 || div_zero !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b q=%h r=%h dz=%b want 1/0/00000064/00000000/0",
                         c, out_valid, in_ready, quotient, remainder, div_zero);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_bypass: valid=%b ready=%b want 0/1", out_valid, in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_single_hs: valid=%b busy=%b want 0/0", out_valid, busy); end
        total++; if (quotient !== 32'd100 || div_zero !== 1'b0) begin bad++; $display("FAIL bp_not_overwritten: q=%h dz=%b want 00000064/0", quotient, div_zero); end
    endtask

    task automatic test_reset_mid_calc();
        int n;
        start_op(32'h0000FFFF, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl: ready=%b valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
        total++; if (quotient !== 32'h0 || remainder !== 32'h0 || div_zero !== 1'b0) begin bad++; $display("FAIL mid_rst_data: q=%h r=%h dz=%b want 0/0/0", quotient, remainder, div_zero); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (35) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_aborted: valid=%b ready=%b want 0/1", out_valid, in_ready); end
        start_op(32'hFFFFFFFF, 32'h10, 1'b0);
        wait_out(n);
        total++; if (n !== 32) begin bad++; $display("FAIL post_rst_latency: got %0d edges want 32", n); end
        total++; if (quotient !== 32'h0FFFFFFF) begin bad++; $display("FAIL post_rst_quotient: got %h want 0fffffff", quotient); end
        total++; if (remainder !== 32'hF) begin bad++; $display("FAIL post_rst_remainder: got %h want 0000000f", remainder); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_calc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width; only 32 is required to be supported.
REQ-002 clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low; released synchronously to clk by the system.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  unit can accept an operand set.
REQ-006 dividend  input  DATA_WIDTH  A operand (numerator).
REQ-007 divisor  input  DATA_WIDTH  B operand (denominator).
REQ-008 is_signed  input  1  1 = two's-complement divide, 0 = unsigned divide.
REQ-009 out_valid  output  1  quotient/remainder/div_zero valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 quotient  output  DATA_WIDTH  registered quotient.
REQ-012 remainder  output  DATA_WIDTH  registered remainder.
REQ-013 div_zero  output  1  result came from a zero divisor.
REQ-014 busy  output  1  high in CALC or DONE.

Function
REQ-015 The state machine SHALL have exactly three states: IDLE, CALC, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept: a clock edge with in_valid=1 in IDLE SHALL latch dividend, divisor and is_signed; inputs SHALL be ignored at every other time.
REQ-018 On accept with divisor!=0: IDLE->CALC, iteration counter loaded with 0.
REQ-019 On accept with divisor==0: IDLE->DONE on that same edge; quotient=all ones, remainder=dividend unmodified, div_zero=1 (signed and unsigned alike).
REQ-020 CALC SHALL perform one restoring-division step per cycle (shift remainder left by 1 bit; bring in the next dividend magnitude bit, MSB first; trial-subtract the divisor magnitude; keep the difference and set the quotient bit to 1 only if the difference is non-negative) for exactly DATA_WIDTH cycles, then go to DONE.
REQ-021 Latency: with the accept edge numbered E0, out_valid SHALL rise after edge E32 for a nonzero divisor and after E0 for a zero divisor.
REQ-022 Signed mode: operate on magnitudes; negate the quotient when the dividend and divisor signs differ; the remainder SHALL take the dividend's sign; remainder magnitude < divisor magnitude.
REQ-023 Signed overflow: dividend=0x80000000, divisor=0xFFFFFFFF SHALL give quotient=0x80000000 and remainder=0 after the normal latency, with div_zero=0 and no other flag raised.
REQ-024 Magnitude and internal remainder datapaths SHALL be DATA_WIDTH+1 bits wide so that 0x80000000 does not wrap.
REQ-025 DONE SHALL hold quotient, remainder and div_zero stable until out_ready=1; the edge with out_valid=1 and out_ready=1 SHALL move the block to IDLE.
REQ-026 A new operand SHALL NOT be accepted on the same edge as the result handshake (in_ready is low in DONE); there SHALL be no back-to-back bypass.
REQ-027 quotient, remainder and div_zero SHALL keep their last values in IDLE and CALC until overwritten by the next completion.
REQ-028 div_zero SHALL be 0 for every nonzero-divisor result.

Reset
REQ-029 While rst_n=0: state=IDLE, in_ready=1, out_valid=0, busy=0, quotient=0, remainder=0, div_zero=0, counter=0.
REQ-030 Asserting rst_n during CALC or DONE SHALL abort the operation immediately with no result produced; the first valid in_valid after release SHALL start a fresh division.

Verification
REQ-031 Unsigned: dividend=100, divisor=7, is_signed=0 -> out_valid after E32, quotient=14, remainder=2, div_zero=0.
REQ-032 Signed: dividend=-100 (0xFFFFFF9C), divisor=7, is_signed=1 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE).
REQ-033 Divide by zero: dividend=0x12345678, divisor=0 -> out_valid after E0, quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1.
REQ-034 Overflow: 0x80000000 / 0xFFFFFFFF, is_signed=1 -> quotient=0x80000000, remainder=0; the same operands with is_signed=0 -> quotient=0, remainder=0x80000000.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; on release, exactly one handshake occurs and then IDLE.
REQ-036 Reset mid-CALC: pull rst_n low at E10 -> all outputs at reset values immediately; after release, 0xFFFFFFFF / 0x10 (unsigned) -> quotient=0x0FFFFFFF, remainder=0xF.
